vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: divides the system clock down to a pixel rate and produces horizontal/vertical sync, active-video, pixel coordinates and line/frame start strobes for any resolution and sync polarity. It sits between the system clock domain and the pixel renderer/DAC. It replaces the fixed 640x480 sync block. All outputs are skew-free flops, and it adds a run/stop enable.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with clock divider and run enable
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   en          run enable; low holds the generator idle at (0,0)
//   p_tick      one-clk pixel strobe, first clk of every pixel
//   x, y        current horizontal / vertical count
//   hsync       horizontal sync, active level HSYNC_POL
//   vsync       vertical sync, active level VSYNC_POL
//   video_on    inside the active display region while running
//   line_start  one-clk pulse on the p_tick where x==0
//   frame_start one-clk pulse on the p_tick where x==0 and y==0
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_DISP   = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_DISP   = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic          run;
    logic [DW-1:0] div;
    logic [CW-1:0] h;
    logic [CW-1:0] v;

    logic          run_n;
    logic [DW-1:0] div_n;
    logic [CW-1:0] h_n;
    logic [CW-1:0] v_n;
    logic          tick_n;
    logic          hs_act_n;
    logic          vs_act_n;
    logic          vid_n;

    assign x = h;
    assign y = v;

    // Next-state of the raster counters. The pixel position advances on the
    // clk that brings div back to 0, so a new pixel always starts together
    // with p_tick and lasts CLK_DIV clks. Leaving run (or not yet being in
    // it) parks every counter at 0, which makes re-enable start at (0,0).
    always_comb begin
        run_n = en;
        div_n = '0;
        h_n   = '0;
        v_n   = '0;
        if (en && run) begin
            div_n = (div == DIV_LAST) ? '0 : div + DW'(1);
            h_n   = h;
            v_n   = v;
            if (div == DIV_LAST) begin
                h_n = (h == H_LAST) ? '0 : h + CW'(1);
                if (h == H_LAST) begin
                    v_n = (v == V_LAST) ? '0 : v + CW'(1);
                end
            end
        end
    end

    // Decode the next state so every registered output lines up with x/y.
    always_comb begin
        tick_n   = run_n && (div_n == '0);
        hs_act_n = (h_n >= HS_FIRST) && (h_n <= HS_LAST);
        vs_act_n = (v_n >= VS_FIRST) && (v_n <= VS_LAST);
        vid_n    = (h_n < H_DISP) && (v_n < V_DISP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run         <= 1'b0;
            div         <= '0;
            h           <= '0;
            v           <= '0;
            p_tick      <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run         <= run_n;
            div         <= div_n;
            h           <= h_n;
            v           <= v_n;
            p_tick      <= tick_n;
            hsync       <= (run_n && hs_act_n) ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= (run_n && vs_act_n) ? VSYNC_POL : ~VSYNC_POL;
            video_on    <= run_n && vid_n;
            line_start  <= tick_n && (h_n == '0);
            frame_start <= tick_n && (h_n == '0) && (v_n == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen over three configurations
module tb_vga_timing_gen;

    typedef struct packed {
        logic        p_tick;
        logic [10:0] x;
        logic [10:0] y;
        logic        hsync;
        logic        vsync;
        logic        video_on;
        logic        line_start;
        logic        frame_start;
    } out_t;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [2:0] en  = 3'b000;

    always #5 clk = ~clk;

    logic        p_tick_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
    logic        p_tick_b, hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
    logic        p_tick_c, hsync_c, vsync_c, video_on_c, line_start_c, frame_start_c;
    logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;

    // A: default 640x480, CLK_DIV=4, active-low syncs
    vga_timing_gen dut_a (
        .clk(clk), .reset(rst[0]), .en(en[0]), .p_tick(p_tick_a), .x(x_a), .y(y_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .line_start(line_start_a), .frame_start(frame_start_a)
    );

    // B: tiny raster, CLK_DIV=1, active-high syncs
    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(11)
    ) dut_b (
        .clk(clk), .reset(rst[1]), .en(en[1]), .p_tick(p_tick_b), .x(x_b), .y(y_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .line_start(line_start_b), .frame_start(frame_start_b)
    );

    // C: mid-size raster, CLK_DIV=3
    vga_timing_gen #(
        .H_DISPLAY(120), .H_FRONT(4), .H_SYNC(8), .H_BACK(8),
        .V_DISPLAY(60), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
        .CLK_DIV(3), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(11)
    ) dut_c (
        .clk(clk), .reset(rst[2]), .en(en[2]), .p_tick(p_tick_c), .x(x_c), .y(y_c),
        .hsync(hsync_c), .vsync(vsync_c), .video_on(video_on_c),
        .line_start(line_start_c), .frame_start(frame_start_c)
    );

    out_t obs_a, obs_b, obs_c;
    assign obs_a = {p_tick_a, x_a, y_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a};
    assign obs_b = {p_tick_b, x_b, y_b, hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b};
    assign obs_c = {p_tick_c, x_c, y_c, hsync_c, vsync_c, video_on_c, line_start_c, frame_start_c};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: expected outputs from the number of clks since the run began.
    function automatic out_t model(input int i, input bit running, input longint t);
        int hd, hf, hs, hb, vd, vf, vs, vb, cd, ht, vt, ph, xx, yy;
        longint p;
        bit hp, vp;
        out_t o;
        case (i)
            0: begin hd=640; hf=16; hs=96; hb=48; vd=480; vf=10; vs=2; vb=33; cd=4; hp=0; vp=0; end
            1: begin hd=4;   hf=1;  hs=2;  hb=1;  vd=3;   vf=1;  vs=1; vb=1;  cd=1; hp=1; vp=1; end
            default: begin hd=120; hf=4; hs=8; hb=8; vd=60; vf=2; vs=2; vb=4; cd=3; hp=0; vp=0; end
        endcase
        o = '0;
        o.hsync = !hp;
        o.vsync = !vp;
        if (!running) return o;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        ph = int'(t % cd);
        p  = t / cd;
        xx = int'(p % ht);
        yy = int'((p / ht) % vt);
        o.p_tick      = (ph == 0);
        o.x           = 11'(xx);
        o.y           = 11'(yy);
        o.hsync       = (xx >= hd + hf && xx < hd + hf + hs) ? hp : !hp;
        o.vsync       = (yy >= vd + vf && yy < vd + vf + vs) ? vp : !vp;
        o.video_on    = (xx < hd) && (yy < vd);
        o.line_start  = (ph == 0) && (xx == 0);
        o.frame_start = (ph == 0) && (xx == 0) && (yy == 0);
        return o;
    endfunction

    bit     run_m [3] = '{0, 0, 0};
    longint t_m   [3] = '{0, 0, 0};
    out_t   q_a[$], q_b[$], q_c[$];
    out_t   e_m;

    // Push the expected output for the state each DUT enters at this edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                run_m[i] = 0;
            end else if (en[i]) begin
                if (run_m[i]) t_m[i] = t_m[i] + 1;
                else begin run_m[i] = 1; t_m[i] = 0; end
            end else begin
                run_m[i] = 0;
            end
            e_m = model(i, run_m[i], t_m[i]);
            case (i)
                0: q_a.push_back(e_m);
                1: q_b.push_back(e_m);
                default: q_c.push_back(e_m);
            endcase
        end
    end

    always @(negedge clk) begin
        if (q_a.size() > 0) check("sb_a", obs_a, q_a.pop_front());
        if (q_b.size() > 0) check("sb_b", obs_b, q_b.pop_front());
        if (q_c.size() > 0) check("sb_c", obs_c, q_c.pop_front());
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check("rst_hsync_a", hsync_a, 1'b1);
        check("rst_vsync_b", vsync_b, 1'b0);
        check("rst_xy_c", {x_c, y_c}, 22'd0);
        check("rst_ptick_b", p_tick_b, 1'b0);
        #1 rst = 3'b000;
        @(negedge clk);
        #1 en = 3'b111;
        @(negedge clk);
        check("start_fs_a", {frame_start_a, line_start_a, video_on_a, p_tick_a}, 4'b1111);
        check("start_xy_a", {x_a, y_a}, 22'd0);

        // Reset A while it sits inside hsync; outputs must clear before any edge.
        guard = 0;
        while (t_m[0] < 2700 && guard < 30000) begin @(negedge clk); guard++; end
        check("wait_a", guard < 30000, 1'b1);
        check("a_in_hsync", hsync_a, 1'b0);
        #1 rst[0] = 1'b1;
        #1;
        check("a_async_hsync", hsync_a, 1'b1);
        check("a_async_xy", {x_a, y_a}, 22'd0);
        check("a_async_vid", {video_on_a, p_tick_a, line_start_a}, 3'b000);
        @(negedge clk);
        #1 rst[0] = 1'b0;
        @(negedge clk);
        check("a_restart", {frame_start_a, x_a, y_a}, {1'b1, 22'd0});

        // Drop C's enable at (100,50), hold off 10 clks, then restart.
        guard = 0;
        while (t_m[2] != 21300 && guard < 30000) begin @(negedge clk); guard++; end
        check("wait_c", guard < 30000, 1'b1);
        check("c_pos", {x_c, y_c}, {11'd100, 11'd50});
        check("c_vid_pre", video_on_c, 1'b1);
        #1 en[2] = 1'b0;
        @(negedge clk);
        check("c_idle", {video_on_c, p_tick_c, line_start_c, frame_start_c, hsync_c}, 5'b00001);
        check("c_idle_xy", {x_c, y_c}, 22'd0);
        repeat (9) @(negedge clk);
        #1 en[2] = 1'b1;
        @(negedge clk);
        check("c_restart", {frame_start_c, line_start_c, video_on_c, p_tick_c}, 4'b1111);
        check("c_restart_xy", {x_c, y_c}, 22'd0);

        repeat (100) @(negedge clk);
        check("b_ptick", p_tick_b, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
